// File: rtl/cache_nway_datapath.sv
// N-way set-associative cache datapath: tag/line arrays, tree-PLRU replacement,
// registered request/response port and a flush sweep with writeback handshake.
`timescale 1ns/1ps
module cache_nway_datapath #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int WAYS     = 4,
    localparam int LINE_B   = 2**S_OFFSET,
    localparam int LINE_W   = 8*LINE_B,
    localparam int NUM_SETS = 2**S_INDEX,
    localparam int WAY_W    = $clog2(WAYS),
    localparam int S_TAG    = 32 - S_OFFSET - S_INDEX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [31:0]       mem_addr,
    input  logic [LINE_W-1:0] data_in,
    input  logic [LINE_B-1:0] byte_en,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [WAY_W-1:0]  rsp_way,
    output logic [LINE_W-1:0] rsp_line,
    output logic [WAY_W-1:0]  rsp_victim_way,
    output logic              rsp_victim_dirty,
    output logic [S_TAG-1:0]  rsp_victim_tag,
    input  logic              flush_start,
    output logic              flush_busy,
    output logic              flush_done,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_addr,
    output logic [LINE_W-1:0] wb_line
);

    typedef enum logic [1:0] {IDLE, SCAN, WB} state_t;

    state_t state;

    logic [S_TAG-1:0]  tag_mem  [NUM_SETS][WAYS];
    logic [LINE_W-1:0] line_mem [NUM_SETS][WAYS];
    logic [NUM_SETS-1:0][WAYS-1:0] valid_q;
    logic [NUM_SETS-1:0][WAYS-1:0] dirty_q;
    logic [NUM_SETS-1:0][WAYS-2:0] plru_q;

    logic [S_INDEX-1:0]       idx;
    logic [S_TAG-1:0]         tag;
    logic                     accept;
    logic                     is_write;
    logic                     is_fill;
    logic                     hit;
    logic [WAY_W-1:0]         hit_way;
    logic                     has_inv;
    logic [WAY_W-1:0]         inv_way;
    logic [WAY_W-1:0]         victim_way;
    logic [WAY_W-1:0]         fill_way;
    logic [LINE_W-1:0]        hit_line;
    logic [LINE_W-1:0]        victim_line;
    logic [LINE_W-1:0]        merged;
    logic [S_INDEX+WAY_W-1:0] scan_ptr;
    logic [S_INDEX-1:0]       scan_set;
    logic [WAY_W-1:0]         scan_way;
    logic                     entry_dirty;
    logic                     entry_done;
    logic                     unused_offset;

    assign idx           = mem_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign tag           = mem_addr[31:S_OFFSET+S_INDEX];
    assign unused_offset = ^mem_addr[S_OFFSET-1:0];
    assign req_ready     = !flush_busy;
    assign accept        = req_valid && req_ready;
    assign is_write      = (req_op == 2'b01);
    assign is_fill       = (req_op == 2'b10);

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; a bit of 1 steers right.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
        int unsigned node;
        node = 0;
        for (int unsigned l = 0; l < WAY_W; l++)
            node = 2*node + 1 + (bits[node] ? 1 : 0);
        return WAY_W'(node - (WAYS-1));
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] r;
        int unsigned node;
        logic dir;
        r = bits;
        node = 0;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            dir     = way[WAY_W-1-l];
            r[node] = ~dir;
            node    = 2*node + 1 + (dir ? 1 : 0);
        end
        return r;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_mem[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        has_inv = 1'b0;
        inv_way = '0;
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (!valid_q[idx][w-1]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w-1);
            end
        end
    end

    assign victim_way  = has_inv ? inv_way : plru_victim(plru_q[idx]);
    assign fill_way    = hit ? hit_way : victim_way;
    assign hit_line    = line_mem[idx][hit_way];
    assign victim_line = line_mem[idx][victim_way];

    always_comb begin
        merged = hit_line;
        for (int unsigned b = 0; b < LINE_B; b++)
            if (byte_en[b]) merged[8*b +: 8] = data_in[8*b +: 8];
    end

    assign scan_set    = scan_ptr[S_INDEX+WAY_W-1:WAY_W];
    assign scan_way    = scan_ptr[WAY_W-1:0];
    assign entry_dirty = valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way];
    assign entry_done  = (state == SCAN && !entry_dirty) || (state == WB && wb_ready);

    // Tag and line payload carry no reset; validity alone decides whether they matter.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (is_fill) begin
                tag_mem[idx][fill_way]  <= tag;
                line_mem[idx][fill_way] <= data_in;
            end else if (is_write && hit) begin
                line_mem[idx][hit_way] <= merged;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            valid_q          <= '0;
            dirty_q          <= '0;
            plru_q           <= '0;
            scan_ptr         <= '0;
            rsp_valid        <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_way          <= '0;
            rsp_line         <= '0;
            rsp_victim_way   <= '0;
            rsp_victim_dirty <= 1'b0;
            rsp_victim_tag   <= '0;
            flush_busy       <= 1'b0;
            flush_done       <= 1'b0;
            wb_valid         <= 1'b0;
            wb_addr          <= '0;
            wb_line          <= '0;
        end else begin
            rsp_valid  <= accept;
            flush_done <= 1'b0;

            if (accept) begin
                rsp_victim_way   <= victim_way;
                rsp_victim_dirty <= dirty_q[idx][victim_way];
                rsp_victim_tag   <= tag_mem[idx][victim_way];
                if (is_fill) begin
                    valid_q[idx][fill_way] <= 1'b1;
                    dirty_q[idx][fill_way] <= 1'b0;
                    plru_q[idx]            <= plru_touch(plru_q[idx], fill_way);
                    rsp_hit                <= 1'b0;
                    rsp_way                <= fill_way;
                    rsp_line               <= data_in;
                end else if (hit) begin
                    plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
                    rsp_hit     <= 1'b1;
                    rsp_way     <= hit_way;
                    if (is_write) begin
                        dirty_q[idx][hit_way] <= 1'b1;
                        rsp_line              <= merged;
                    end else begin
                        rsp_line <= hit_line;
                    end
                end else begin
                    rsp_hit  <= 1'b0;
                    rsp_way  <= victim_way;
                    rsp_line <= victim_line;
                end
            end

            case (state)
                IDLE: begin
                    if (flush_start) begin
                        state      <= SCAN;
                        flush_busy <= 1'b1;
                        scan_ptr   <= '0;
                    end
                end
                SCAN: begin
                    if (entry_dirty) begin
                        state    <= WB;
                        wb_valid <= 1'b1;
                        wb_addr  <= {tag_mem[scan_set][scan_way], scan_set, {S_OFFSET{1'b0}}};
                        wb_line  <= line_mem[scan_set][scan_way];
                    end
                end
                WB: ;
                default: state <= IDLE;
            endcase

            if (entry_done) begin
                valid_q[scan_set][scan_way] <= 1'b0;
                dirty_q[scan_set][scan_way] <= 1'b0;
                wb_valid                    <= 1'b0;
                if (&scan_ptr) begin
                    state      <= IDLE;
                    flush_busy <= 1'b0;
                    flush_done <= 1'b1;
                    plru_q     <= '0;
                end else begin
                    state    <= SCAN;
                    scan_ptr <= scan_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_nway_datapath.sv
// Directed self-checking bench for cache_nway_datapath (default parameters: 4 ways, 8 sets, 32-byte lines).
`timescale 1ns/1ps
module tb_cache_nway_datapath;

    localparam int S_OFFSET = 5;
    localparam int S_INDEX  = 3;
    localparam int WAYS     = 4;
    localparam int LINE_B   = 32;
    localparam int LINE_W   = 256;
    localparam int WAY_W    = 2;
    localparam int S_TAG    = 24;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [31:0]       mem_addr;
    logic [LINE_W-1:0] data_in;
    logic [LINE_B-1:0] byte_en;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [WAY_W-1:0]  rsp_way;
    logic [LINE_W-1:0] rsp_line;
    logic [WAY_W-1:0]  rsp_victim_way;
    logic              rsp_victim_dirty;
    logic [S_TAG-1:0]  rsp_victim_tag;
    logic              flush_start;
    logic              flush_busy;
    logic              flush_done;
    logic              wb_valid;
    logic              wb_ready;
    logic [31:0]       wb_addr;
    logic [LINE_W-1:0] wb_line;

    int errors = 0;
    int checks = 0;
    int scan_cnt;
    int wb_cnt;

    cache_nway_datapath #(.S_OFFSET(S_OFFSET), .S_INDEX(S_INDEX), .WAYS(WAYS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .mem_addr(mem_addr), .data_in(data_in), .byte_en(byte_en),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_line(rsp_line),
        .rsp_victim_way(rsp_victim_way), .rsp_victim_dirty(rsp_victim_dirty),
        .rsp_victim_tag(rsp_victim_tag),
        .flush_start(flush_start), .flush_busy(flush_busy), .flush_done(flush_done),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_line(wb_line)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] op, input logic [31:0] addr,
                       input logic [LINE_W-1:0] data, input logic [LINE_B-1:0] be);
        req_valid = 1'b1;
        req_op    = op;
        mem_addr  = addr;
        data_in   = data;
        byte_en   = be;
        step();
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] addr_of(input int t, input int set);
        return 32'((t << 8) | (set << 5));
    endfunction

    function automatic logic [LINE_W-1:0] pat(input int t);
        return {8{32'h5A00_0000 + 32'(t)}};
    endfunction

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = OP_READ; mem_addr = '0;
        data_in = '0; byte_en = '0; flush_start = 1'b0; wb_ready = 1'b0;
        step();
        step();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_flush_busy", flush_busy, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_flush_done", flush_done, 0);
        rst = 1'b0;
        chk("rst_req_ready", req_ready, 1);

        // Cold miss
        req(OP_READ, 32'h0000_1040, '0, '0);
        chk("cold_rsp_valid", rsp_valid, 1);
        chk("cold_hit", rsp_hit, 0);
        chk("cold_victim_way", rsp_victim_way, 0);
        chk("cold_victim_dirty", rsp_victim_dirty, 0);
        step();
        chk("rsp_valid_pulse", rsp_valid, 0);

        // Fill index 2 with tags 1..4 into ways 0..3
        for (int t = 1; t <= 4; t++) begin
            req(OP_FILL, addr_of(t, 2), pat(t), '0);
            chk("fill_way", rsp_way, LINE_W'(t - 1));
            chk("fill_hit", rsp_hit, 0);
        end
        req(OP_READ, addr_of(1, 2), '0, '0);
        chk("rd_t1_hit", rsp_hit, 1);
        chk("rd_t1_way", rsp_way, 0);
        chk("rd_t1_line", rsp_line, pat(1));
        req(OP_READ, addr_of(3, 2), '0, '0);
        chk("rd_t3_hit", rsp_hit, 1);
        chk("rd_t3_way", rsp_way, 2);
        req(OP_FILL, addr_of(5, 2), pat(5), '0);
        chk("plru_fill_way", rsp_way, 1);
        chk("plru_fill_victim", rsp_victim_way, 1);
        chk("plru_fill_victim_tag", rsp_victim_tag, 24'h2);
        req(OP_READ, addr_of(2, 2), '0, '0);
        chk("evicted_t2_hit", rsp_hit, 0);
        chk("evicted_t2_victim", rsp_victim_way, 3);
        chk("evicted_t2_victim_tag", rsp_victim_tag, 24'h4);
        req(OP_RSVD, addr_of(5, 2), '0, '0);
        chk("rsvd_op_hit", rsp_hit, 1);
        chk("rsvd_op_way", rsp_way, 1);
        chk("rsvd_op_line", rsp_line, pat(5));

        // Partial write then back-to-back read
        req(OP_FILL, 32'h0000_0020, {32{8'h11}}, '0);
        chk("fill20_way", rsp_way, 0);
        req(OP_WRITE, 32'h0000_0020, {{28{8'hEE}}, 32'hAABB_CCDD}, 32'h0000_000F);
        chk("wr_hit", rsp_hit, 1);
        chk("wr_line", rsp_line, {{28{8'h11}}, 32'hAABB_CCDD});
        req(OP_READ, 32'h0000_0020, '0, '0);
        chk("b2b_rd_hit", rsp_hit, 1);
        chk("b2b_rd_line", rsp_line, {{28{8'h11}}, 32'hAABB_CCDD});
        for (int t = 1; t <= 3; t++) req(OP_FILL, addr_of(t, 1), pat(16 + t), '0);
        req(OP_READ, addr_of(9, 1), '0, '0);
        chk("full_miss_hit", rsp_hit, 0);
        chk("full_miss_victim", rsp_victim_way, 0);
        chk("full_miss_dirty", rsp_victim_dirty, 1);
        chk("full_miss_line", rsp_line, {{28{8'h11}}, 32'hAABB_CCDD});
        req(OP_READ, addr_of(0, 1), '0, '0);
        req(OP_READ, addr_of(9, 1), '0, '0);
        chk("clean_victim_way", rsp_victim_way, 2);
        chk("clean_victim_dirty", rsp_victim_dirty, 0);
        req(OP_WRITE, addr_of(9, 1), {32{8'h33}}, '1);
        chk("wr_miss_hit", rsp_hit, 0);
        req(OP_READ, addr_of(9, 1), '0, '0);
        chk("wr_miss_nochange", rsp_hit, 0);

        // Flush with two dirty lines (sets 0 and 7) and one clean line
        do_reset();
        req(OP_FILL, 32'h0000_0A00, pat(10), '0);
        req(OP_WRITE, 32'h0000_0A00, {32{8'h77}}, '1);
        chk("dirty_a00_hit", rsp_hit, 1);
        req(OP_FILL, 32'h0000_0BE0, pat(11), '0);
        req(OP_WRITE, 32'h0000_0BE0, {32{8'h88}}, '1);
        req(OP_FILL, 32'h0000_0C60, pat(12), '0);
        flush_start = 1'b1;
        req(OP_READ, 32'h0000_0C60, '0, '0);
        flush_start = 1'b0;
        chk("flush_same_cycle_rsp", rsp_valid, 1);
        chk("flush_same_cycle_hit", rsp_hit, 1);
        chk("flush_busy_set", flush_busy, 1);
        chk("flush_req_ready", req_ready, 0);
        scan_cnt = 0;
        wb_cnt   = 0;
        for (int i = 0; i < 40 && !wb_valid; i++) begin
            if (flush_busy) scan_cnt++;
            step();
        end
        chk("wb1_valid", wb_valid, 1);
        chk("wb1_addr", wb_addr, 32'h0000_0A00);
        chk("wb1_line", wb_line, {32{8'h77}});
        req_valid = 1'b1;
        req_op    = OP_READ;
        mem_addr  = 32'h0000_0C60;
        repeat (3) begin
            step();
            chk("wb1_hold_valid", wb_valid, 1);
            chk("wb1_hold_addr", wb_addr, 32'h0000_0A00);
            chk("wb1_hold_line", wb_line, {32{8'h77}});
            chk("busy_no_rsp", rsp_valid, 0);
            chk("busy_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        wb_ready  = 1'b1;
        step();
        wb_cnt++;
        chk("wb1_released", wb_valid, 0);
        for (int i = 0; i < 100 && !flush_done; i++) begin
            if (wb_valid) begin
                wb_cnt++;
                chk("wb2_addr", wb_addr, 32'h0000_0BE0);
                chk("wb2_line", wb_line, {32{8'h88}});
            end else if (flush_busy) begin
                scan_cnt++;
            end
            step();
        end
        chk("flush_done", flush_done, 1);
        chk("flush_busy_clr", flush_busy, 0);
        chk("scan_steps", scan_cnt, 32);
        chk("wb_count", wb_cnt, 2);
        step();
        wb_ready = 1'b0;
        chk("flush_done_pulse", flush_done, 0);
        chk("post_flush_ready", req_ready, 1);
        req(OP_READ, 32'h0000_0A00, '0, '0);
        chk("post_flush_a00", rsp_hit, 0);
        chk("post_flush_victim", rsp_victim_way, 0);
        req(OP_READ, 32'h0000_0BE0, '0, '0);
        chk("post_flush_be0", rsp_hit, 0);
        req(OP_READ, 32'h0000_0C60, '0, '0);
        chk("post_flush_c60", rsp_hit, 0);

        // Reset while a writeback is pending
        req(OP_FILL, 32'h0000_0300, pat(3), '0);
        req(OP_WRITE, 32'h0000_0300, {32{8'h99}}, '1);
        flush_start = 1'b1;
        step();
        flush_start = 1'b0;
        for (int i = 0; i < 40 && !wb_valid; i++) step();
        chk("abort_wb_valid", wb_valid, 1);
        chk("abort_wb_addr", wb_addr, 32'h0000_0300);
        rst = 1'b1;
        #1;
        chk("abort_wb_cleared", wb_valid, 0);
        chk("abort_busy_cleared", flush_busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_req_ready", req_ready, 1);
        req(OP_READ, 32'h0000_0300, '0, '0);
        chk("abort_line_invalid", rsp_hit, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
